instr_prefetch_buffer: RTL and testbench

Fetch-side controller that sequences the single-port, combinational-read instruction memory (32 words, byte-addressed, word index = addr/4). It generates a sequential fetch address every cycle, captures the returned word together with its PC into a small FIFO, and presents instructions to the decode stage over a valid/ready handshake. A redirect input (branch/jump taken) flushes the FIFO and restarts fetch at a new PC.

---
 rtl/instr_prefetch_buffer.sv | 106 ++++++++++
 tb/tb_instr_prefetch_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction fetch into a small {pc, instr} FIFO feeding decode over valid/ready.
// A redirect flushes the FIFO and restarts fetch; fetch parks in END once the memory is exhausted.
module instr_prefetch_buffer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
);

    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam logic [31:0]        LIMIT    = 32'(MEM_WORDS * 4);

    typedef enum logic {
        ST_RUN,
        ST_END
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [31:0]        fifo_pc    [DEPTH];
    logic [31:0]        fifo_instr [DEPTH];

    logic               push;
    logic               pop;
    logic               not_empty;
    logic [31:0]        redirect_pc_al;
    logic [31:0]        fetch_pc_next;

    function automatic logic in_range(input logic [31:0] pc);
        return (pc < LIMIT);
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

    assign not_empty      = (count != '0);
    assign redirect_pc_al = align_word(redirect_pc_i);
    assign fetch_pc_next  = fetch_pc + 32'd4;

    // Redirect cancels the head handshake: the entry is flushed, not consumed.
    assign pop  = not_empty & instr_ready_i & ~redirect_i;
    assign push = (state == ST_RUN) & ~redirect_i & ((count < FULL_CNT) | pop);

    assign mem_addr_o    = fetch_pc;
    assign instr_valid_o = not_empty;
    assign instr_o       = not_empty ? fifo_instr[rd_ptr] : 32'h0;
    assign pc_o          = not_empty ? fifo_pc[rd_ptr]    : 32'h0;

    // Entry storage carries no reset; occupancy is tracked solely by count/pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= mem_instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= in_range(RESET_PC) ? ST_RUN : ST_END;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_al;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= in_range(redirect_pc_al) ? ST_RUN : ST_END;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc_next;
                if (!in_range(fetch_pc_next)) begin
                    state <= ST_END;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer; memory word i reads as 32'h1000_0000 + i.
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_ready;

    int n_cmp;
    int n_bad;

    instr_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(32)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .mem_addr_o   (mem_addr),
        .mem_instr_i  (mem_instr),
        .instr_valid_o(instr_valid),
        .instr_o      (instr),
        .pc_o         (pc),
        .instr_ready_i(instr_ready)
    );

    assign mem_instr = 32'h1000_0000 + {2'b00, mem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in cycle 0: rst just deasserted, first push at the next edge.
    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b1;

        // Streaming the whole memory with decode always ready.
        do_reset();
        check("s_c0_valid", {31'h0, instr_valid}, 32'h0);
        for (int n = 1; n <= 32; n++) begin
            tick();
            check("s_valid", {31'h0, instr_valid}, 32'h1);
            check("s_pc", pc, 32'(4 * (n - 1)));
            check("s_instr", instr, 32'h1000_0000 + 32'(n - 1));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("end_valid", {31'h0, instr_valid}, 32'h0);
            check("end_addr", mem_addr, 32'd128);
            check("end_pc", pc, 32'h0);
        end

        // Back-pressure: FIFO fills to 4, fetch address parks at 16.
        instr_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 10; k++) tick();
        check("bp_valid", {31'h0, instr_valid}, 32'h1);
        check("bp_pc", pc, 32'h0);
        check("bp_instr", instr, 32'h1000_0000);
        check("bp_addr", mem_addr, 32'd16);
        instr_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("bp_drain_pc", pc, 32'(4 * j));
            check("bp_drain_valid", {31'h0, instr_valid}, 32'h1);
        end

        // Redirect at cycle 5 to an unaligned target.
        do_reset();
        for (int k = 1; k <= 5; k++) tick();
        check("rd_c5_pc", pc, 32'd16);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0042;
        tick();
        redirect = 1'b0;
        check("rd_c6_valid", {31'h0, instr_valid}, 32'h0);
        check("rd_c6_addr", mem_addr, 32'h40);
        check("rd_c6_instr", instr, 32'h0);
        tick();
        check("rd_c7_valid", {31'h0, instr_valid}, 32'h1);
        check("rd_c7_pc", pc, 32'h40);
        check("rd_c7_instr", instr, 32'h1000_0010);
        tick();
        check("rd_c8_pc", pc, 32'h44);

        // Redirect while a full FIFO's head is being handshaken.
        instr_ready = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("hs_full_pc", pc, 32'h44);
        check("hs_full_addr", mem_addr, 32'h54);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0020;
        tick();
        redirect = 1'b0;
        check("hs_bubble_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("hs_first_pc", pc, 32'h20);
        tick();
        check("hs_second_pc", pc, 32'h24);

        // Out-of-range redirect parks fetch; in-range redirect resumes it.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("oor_valid", {31'h0, instr_valid}, 32'h0);
            check("oor_addr", mem_addr, 32'h200);
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0008;
        tick();
        redirect = 1'b0;
        check("resume_bubble", {31'h0, instr_valid}, 32'h0);
        check("resume_addr", mem_addr, 32'h8);
        tick();
        check("resume_valid", {31'h0, instr_valid}, 32'h1);
        check("resume_pc", pc, 32'h8);
        check("resume_instr", instr, 32'h1000_0002);

        // Reset and redirect together with three entries queued: reset wins.
        instr_ready = 1'b0;
        do_reset();
        for (int k = 1; k <= 3; k++) tick();
        check("rr_pre_pc", pc, 32'h0);
        check("rr_pre_addr", mem_addr, 32'd12);
        rst         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        rst      = 1'b0;
        redirect = 1'b0;
        check("rr_valid", {31'h0, instr_valid}, 32'h0);
        check("rr_instr", instr, 32'h0);
        check("rr_pc", pc, 32'h0);
        check("rr_addr", mem_addr, 32'h0);
        tick();
        check("rr_after_valid", {31'h0, instr_valid}, 32'h1);
        check("rr_after_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
